// File: rtl/word_packer_pkg.sv
// Shared types and default sizing for the word_packer slice.
// The optional running sum is enabled by defining WORD_PACKER_SUM_EN.
package word_packer_pkg;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int NB_DATA_DEF = 8;
    localparam int N_WORD_DEF  = 8;
    localparam int NB_TOTAL    = NB_DATA_DEF * N_WORD_DEF;
    localparam int NB_PTR      = $clog2(N_WORD_DEF);
    localparam int NB_SUM      = NB_DATA_DEF + NB_PTR;

endpackage

// File: rtl/word_packer_acc.sv
// Signed load/accumulate register producing the running sum of a frame.
// Only instantiated when WORD_PACKER_SUM_EN is defined.
module word_packer_acc
    import word_packer_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_ACC  = NB_SUM
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     i_en,
    input  logic                     i_load,
    input  logic [NB_DATA-1:0]       i_data,
    output logic signed [NB_ACC-1:0] o_sum
);

    logic signed [NB_ACC-1:0] r_sum;
    logic signed [NB_ACC-1:0] w_word;

    assign w_word = signed'({{(NB_ACC - NB_DATA){i_data[NB_DATA-1]}}, i_data});

    // The first word of a frame loads, later words add; width covers the full frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sum <= '0;
        end else if (i_en) begin
            if (i_load) begin
                r_sum <= w_word;
            end else begin
                r_sum <= r_sum + w_word;
            end
        end
    end

    assign o_sum = r_sum;

endmodule

// File: rtl/word_packer.sv
// Streaming packer: N_WORD words of NB_DATA bits into one flat frame, word 0 at the LSBs.
// Define WORD_PACKER_SUM_EN to add the o_sum port with a signed frame sum.
module word_packer
    import word_packer_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int N_WORD  = N_WORD_DEF
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NB_DATA-1:0]            i_data,
    input  logic                          i_valid,
    output logic                          o_ready,
    output logic [NB_DATA*N_WORD-1:0]     o_data,
    output logic                          o_valid,
    input  logic                          i_ready
`ifdef WORD_PACKER_SUM_EN
    ,
    output logic signed [NB_DATA+$clog2(N_WORD)-1:0] o_sum
`endif
);

    localparam int L_TOTAL = NB_DATA * N_WORD;
    localparam int L_PTR   = $clog2(N_WORD);
    localparam int L_SUM   = NB_DATA + L_PTR;
    localparam logic [L_PTR-1:0] PTR_LAST = L_PTR'(N_WORD - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [L_PTR-1:0]   r_ptr;
    logic [L_PTR-1:0]   w_ptr_nxt;
    logic               r_valid;
    logic               w_ready;
    logic               w_accept;
    logic [N_WORD-1:0]  w_slot_en;
    logic [L_TOTAL-1:0] w_frame;

    // Ready never looks at i_valid; it is held low while reset is asserted.
    assign w_ready  = !reset && ((r_state == FILL) || i_ready);
    assign w_accept = i_valid && w_ready;

    // Next-state and slot pointer; a release with a word waiting starts the next frame at slot 1.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            FILL: begin
                if (w_accept) begin
                    if (r_ptr == PTR_LAST) begin
                        w_ptr_nxt   = '0;
                        w_state_nxt = HOLD;
                    end else begin
                        w_ptr_nxt   = r_ptr + L_PTR'(1);
                        w_state_nxt = FILL;
                    end
                end else begin
                    w_ptr_nxt   = r_ptr;
                    w_state_nxt = FILL;
                end
            end
            HOLD: begin
                if (i_ready) begin
                    w_state_nxt = FILL;
                    w_ptr_nxt   = w_accept ? L_PTR'(1) : '0;
                end else begin
                    w_state_nxt = HOLD;
                    w_ptr_nxt   = r_ptr;
                end
            end
            default: begin
                w_state_nxt = FILL;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    // State, pointer and registered frame-valid flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= FILL;
            r_ptr   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_valid <= (w_state_nxt == HOLD);
        end
    end

    for (genvar k = 0; k < N_WORD; k++) begin : g_slot
        logic [NB_DATA-1:0] r_word;

        assign w_slot_en[k] = w_accept && (r_ptr == L_PTR'(k));

        // One slot register; untouched slots keep stale contents.
        always_ff @(posedge clock) begin
            if (reset) begin
                r_word <= '0;
            end else if (w_slot_en[k]) begin
                r_word <= i_data;
            end
        end

        assign w_frame[k*NB_DATA +: NB_DATA] = r_word;
    end

    assign o_ready = w_ready;
    assign o_valid = r_valid;
    assign o_data  = w_frame;

`ifdef WORD_PACKER_SUM_EN
    word_packer_acc #(
        .NB_DATA (NB_DATA),
        .NB_ACC  (L_SUM)
    ) u_acc (
        .clock  (clock),
        .reset  (reset),
        .i_en   (w_accept),
        .i_load (r_ptr == '0),
        .i_data (i_data),
        .o_sum  (o_sum)
    );
`endif

endmodule

// File: tb/tb_word_packer.sv
// Directed self-checking bench for word_packer (NB_DATA=8, N_WORD=8).
// Sum checks run only when WORD_PACKER_SUM_EN is defined.
module tb_word_packer;

    logic        clock;
    logic        reset;
    logic [7:0]  i_data;
    logic        i_valid;
    logic        o_ready;
    logic [63:0] o_data;
    logic        o_valid;
    logic        i_ready;
`ifdef WORD_PACKER_SUM_EN
    logic signed [10:0] o_sum;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    word_packer #(
        .NB_DATA (8),
        .N_WORD  (8)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .i_data  (i_data),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_valid (o_valid),
        .i_ready (i_ready)
`ifdef WORD_PACKER_SUM_EN
        ,
        .o_sum   (o_sum)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic [7:0] d, input logic r);
        i_valid = v;
        i_data  = d;
        i_ready = r;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        set_in(1'b0, 8'h00, 1'b1);
        repeat (2) @(posedge clock);
        #1;
        @(negedge clock);
        check("rst_ready_low", {63'd0, o_ready}, 64'd0);
        check("rst_valid_low", {63'd0, o_valid}, 64'd0);
        next_cycle();
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_ready", {63'd0, o_ready}, 64'd1);
        check("post_rst_valid", {63'd0, o_valid}, 64'd0);
        check("post_rst_data", o_data, 64'd0);
`ifdef WORD_PACKER_SUM_EN
        check("post_rst_sum", {53'd0, o_sum}, 64'd0);
`endif
        next_cycle();

        // Basic frame 0x01..0x08
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, 8'(i + 1), 1'b1);
            @(negedge clock);
            check("t1_valid_low", {63'd0, o_valid}, 64'd0);
            next_cycle();
        end
        set_in(1'b0, 8'h00, 1'b1);
        @(negedge clock);
        check("t1_valid", {63'd0, o_valid}, 64'd1);
        check("t1_data", o_data, 64'h0807060504030201);
        next_cycle();
        @(negedge clock);
        check("t1_single_pulse", {63'd0, o_valid}, 64'd0);
        next_cycle();

        // Stall for 5 cycles, then release with a word waiting
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, 8'(8'h11 + i), 1'b0);
            next_cycle();
        end
        set_in(1'b1, 8'h55, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("t2_stall_ready", {63'd0, o_ready}, 64'd0);
            check("t2_stall_valid", {63'd0, o_valid}, 64'd1);
            check("t2_stall_data", o_data, 64'h1817161514131211);
            next_cycle();
        end
        set_in(1'b1, 8'h55, 1'b1);
        @(negedge clock);
        check("t2_release_ready", {63'd0, o_ready}, 64'd1);
        check("t2_release_valid", {63'd0, o_valid}, 64'd1);
        next_cycle();
        set_in(1'b0, 8'h00, 1'b1);
        @(negedge clock);
        check("t2_delivered_once", {63'd0, o_valid}, 64'd0);
        next_cycle();
        for (int i = 0; i < 7; i++) begin
            set_in(1'b1, 8'(8'h56 + i), 1'b1);
            next_cycle();
        end
        set_in(1'b0, 8'h00, 1'b0);
        @(negedge clock);
        check("t2_slot0_valid", {63'd0, o_valid}, 64'd1);
        check("t2_slot0_data", o_data, 64'h5C5B5A5958575655);
        next_cycle();

        // Two frames streamed back to back, starting from a held frame
        for (int i = 0; i < 16; i++) begin
            set_in(1'b1, 8'(i + 1), 1'b1);
            @(negedge clock);
            check("t3_ready", {63'd0, o_ready}, 64'd1);
            check("t3_valid", {63'd0, o_valid}, {63'd0, (i == 0 || i == 8)});
            if (i == 8) begin
                check("t3_frame1", o_data, 64'h0807060504030201);
            end
            next_cycle();
        end
        set_in(1'b0, 8'h00, 1'b1);
        @(negedge clock);
        check("t3_frame2_valid", {63'd0, o_valid}, 64'd1);
        check("t3_frame2", o_data, 64'h100F0E0D0C0B0A09);
        next_cycle();

        // Partial frame dropped by reset
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 8'(8'h31 + i), 1'b1);
            next_cycle();
        end
        reset = 1'b1;
        set_in(1'b0, 8'h00, 1'b1);
        @(negedge clock);
        check("t4_rst_ready", {63'd0, o_ready}, 64'd0);
        check("t4_rst_valid", {63'd0, o_valid}, 64'd0);
        next_cycle();
        reset = 1'b0;
        @(negedge clock);
        check("t4_after_rst_valid", {63'd0, o_valid}, 64'd0);
        check("t4_after_rst_data", o_data, 64'd0);
        next_cycle();
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, 8'(8'hA0 + i), 1'b1);
            @(negedge clock);
            check("t4_fill_valid", {63'd0, o_valid}, 64'd0);
            next_cycle();
        end
        set_in(1'b0, 8'h00, 1'b1);
        @(negedge clock);
        check("t4_valid", {63'd0, o_valid}, 64'd1);
        check("t4_data", o_data, 64'hA7A6A5A4A3A2A1A0);
        next_cycle();

        // i_valid every other cycle, junk data on idle cycles
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) begin
                set_in(1'b1, 8'(8'hC0 + i / 2), 1'b1);
            end else begin
                set_in(1'b0, 8'hEE, 1'b1);
            end
            @(negedge clock);
            check("t5_valid", {63'd0, o_valid}, {63'd0, (i == 15)});
            if (i == 15) begin
                check("t5_data", o_data, 64'hC7C6C5C4C3C2C1C0);
            end
            next_cycle();
        end

`ifdef WORD_PACKER_SUM_EN
        set_in(1'b0, 8'h00, 1'b1);
        next_cycle();
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, 8'h80, 1'b1);
            next_cycle();
        end
        set_in(1'b0, 8'h00, 1'b0);
        @(negedge clock);
        check("t6_neg_valid", {63'd0, o_valid}, 64'd1);
        check("t6_sum_neg", {53'd0, o_sum}, 64'h400);
        next_cycle();
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, 8'h7F, 1'b1);
            next_cycle();
        end
        set_in(1'b0, 8'h00, 1'b1);
        @(negedge clock);
        check("t6_pos_valid", {63'd0, o_valid}, 64'd1);
        check("t6_sum_pos", {53'd0, o_sum}, 64'h3F8);
        next_cycle();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
